parking_pin_transmitter: RTL and testbench

Keypad-side front end for the parking gate controller. Collects four BCD digits from the keypad, presents them as a 16-bit PIN with a held `code_ack` strobe, then tracks the controller's `open_gate` / `blocked_gate` response. Sits between the keypad scanner and the gate controller's `code` / `code_ack` inputs. Counts rejected attempts locally for the driver display.

---
 rtl/parking_pin_if.sv | 25 ++
 rtl/parking_pin_transmitter.sv | 135 +++++++++++++
 tb/tb_parking_pin_transmitter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/parking_pin_if.sv
// Keypad and gate-controller signal bundle for the parking PIN transmitter.
interface parking_pin_if;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        key_enter;
  logic        key_clear;
  logic        open_gate;
  logic        blocked_gate;
  logic [15:0] code;
  logic        code_ack;
  logic [2:0]  digit_count;
  logic [1:0]  rejected;
  logic        granted;
  logic        locked;

  modport master (
    output key_valid, key_digit, key_enter, key_clear, open_gate, blocked_gate,
    input  code, code_ack, digit_count, rejected, granted, locked
  );

  modport slave (
    input  key_valid, key_digit, key_enter, key_clear, open_gate, blocked_gate,
    output code, code_ack, digit_count, rejected, granted, locked
  );
endinterface

// File: rtl/parking_pin_transmitter.sv
// Collects four BCD digits, strobes them to the gate controller and tracks the
// grant / lockout / timeout outcome of each submission.
module parking_pin_transmitter #(
  parameter int unsigned ACK_CYCLES   = 2,
  parameter int unsigned RESP_TIMEOUT = 8
) (
  input logic          clk,
  input logic          rst,
  parking_pin_if.slave bus
);

  localparam int unsigned ACK_W = 4;
  localparam int unsigned TMO_W = 8;
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESP_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] GAP_INIT = TMO_W'(RESP_TIMEOUT);

  typedef enum logic [2:0] {
    ENTRY,
    SEND,
    WAIT_RESP,
    GRANTED,
    LOCKED
  } state_t;

  state_t           state;
  logic [15:0]      code;
  logic             code_ack;
  logic [2:0]       digit_count;
  logic [1:0]       rejected;
  logic             granted;
  logic             locked;
  logic [ACK_W-1:0] ack_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  // Holds off resubmission so code_ack stays low long enough after a return to ENTRY.
  logic [TMO_W-1:0] gap_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ENTRY;
      code        <= '0;
      code_ack    <= 1'b0;
      digit_count <= '0;
      rejected    <= '0;
      granted     <= 1'b0;
      locked      <= 1'b0;
      ack_cnt     <= '0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
    end else begin
      case (state)
        ENTRY: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - TMO_W'(1);
          if (bus.blocked_gate) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end else if (bus.key_clear) begin
            code        <= '0;
            digit_count <= '0;
          end else if (bus.key_valid) begin
            if (bus.key_digit <= 4'd9 && digit_count < 3'd4) begin
              code        <= {code[11:0], bus.key_digit};
              digit_count <= digit_count + 3'd1;
            end
          end else if (bus.key_enter && digit_count == 3'd4 && gap_cnt == '0) begin
            state    <= SEND;
            code_ack <= 1'b1;
            ack_cnt  <= '0;
          end
        end

        SEND: begin
          if (bus.blocked_gate) begin
            state    <= LOCKED;
            code_ack <= 1'b0;
            locked   <= 1'b1;
          end else if (ack_cnt == ACK_LAST) begin
            state    <= WAIT_RESP;
            code_ack <= 1'b0;
            tmo_cnt  <= '0;
          end else begin
            ack_cnt <= ack_cnt + ACK_W'(1);
          end
        end

        WAIT_RESP: begin
          if (bus.blocked_gate) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end else if (bus.open_gate) begin
            state   <= GRANTED;
            granted <= 1'b1;
          end else if (tmo_cnt == TMO_LAST) begin
            state       <= ENTRY;
            code        <= '0;
            digit_count <= '0;
            gap_cnt     <= GAP_INIT;
            if (rejected != 2'd3) rejected <= rejected + 2'd1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        GRANTED: begin
          if (bus.blocked_gate) begin
            state   <= LOCKED;
            granted <= 1'b0;
            locked  <= 1'b1;
          end else if (!bus.open_gate) begin
            state       <= ENTRY;
            granted     <= 1'b0;
            code        <= '0;
            digit_count <= '0;
            rejected    <= '0;
            gap_cnt     <= GAP_INIT;
          end
        end

        LOCKED: begin
          code_ack <= 1'b0;
        end

        default: state <= ENTRY;
      endcase
    end
  end

  assign bus.code        = code;
  assign bus.code_ack    = code_ack;
  assign bus.digit_count = digit_count;
  assign bus.rejected    = rejected;
  assign bus.granted     = granted;
  assign bus.locked      = locked;

endmodule

// File: tb/tb_parking_pin_transmitter.sv
// Directed scoreboard bench: stimulus queues the expected output snapshots and
// their cycle stamps, a negedge monitor checks every output change against them.
module tb_parking_pin_transmitter;

  localparam int ACK = 2;
  localparam int RT  = 8;

  typedef struct packed {
    logic [15:0] code;
    logic        ack;
    logic [2:0]  cnt;
    logic [1:0]  rej;
    logic        granted;
    logic        locked;
  } snap_t;

  typedef struct {
    snap_t s;
    int    at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  bit   sync_req = 1'b0;
  snap_t e;
  snap_t prev;
  exp_t  q[$];

  parking_pin_if bus ();

  parking_pin_transmitter #(.ACK_CYCLES(ACK), .RESP_TIMEOUT(RT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  // Monitor: any change on the outputs must match the next queued snapshot at its cycle.
  always @(negedge clk) begin
    snap_t cur;
    exp_t  x;
    cur = {bus.code, bus.code_ack, bus.digit_count, bus.rejected, bus.granted, bus.locked};
    if (mon_en && (sync_req || cur != prev)) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, cur);
      end else begin
        x = q.pop_front();
        if (cur != x.s || (!sync_req && cyc != x.at)) begin
          miscompares++;
          $display("FAIL output_snapshot cyc=%0d got=%h required=%h at cyc=%0d",
                   cyc, cur, x.s, x.at);
        end
      end
      sync_req = 1'b0;
    end
    prev = cur;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int at);
    exp_t x;
    x.s  = e;
    x.at = at;
    q.push_back(x);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    e = '0;
    push(cyc);
    sync_req = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic key(input logic [3:0] d);
    bus.key_valid = 1'b1;
    bus.key_digit = d;
    if (d <= 4'd9 && e.cnt < 3'd4) begin
      e.code = {e.code[11:0], d};
      e.cnt  = e.cnt + 3'd1;
      push(cyc + 1);
    end
    tick(1);
    bus.key_valid = 1'b0;
    bus.key_digit = 4'd0;
  endtask

  task automatic pulse_enter_ignored();
    bus.key_enter = 1'b1;
    tick(1);
    bus.key_enter = 1'b0;
  endtask

  // Accepted enter: ack rises after the sampling edge and falls ACK edges later.
  task automatic submit();
    bus.key_enter = 1'b1;
    e.ack = 1'b1;
    push(cyc + 1);
    e.ack = 1'b0;
    push(cyc + 1 + ACK);
    tick(1);
    bus.key_enter = 1'b0;
  endtask

  task automatic submit_timeout(input logic [1:0] rej_after);
    int t;
    submit();
    t = cyc + ACK;
    e.code = '0;
    e.cnt  = '0;
    e.rej  = rej_after;
    push(t + RT);
    tick(ACK + RT);
    tick(RT);
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_digit = 4'd0;
    bus.key_enter = 1'b0;
    bus.key_clear = 1'b0;
    bus.open_gate = 1'b0;
    bus.blocked_gate = 1'b0;
    e = '0;
    prev = '0;
    #1;
    do_reset();
    tick(2);

    // Grant path: 2468, open_gate three cycles after ack falls.
    key(4'd2); key(4'd4); key(4'd6); key(4'd8);
    submit();
    begin
      int t;
      t = cyc + ACK;
      tick(ACK + 2);
      bus.open_gate = 1'b1;
      e.granted = 1'b1;
      push(t + 3);
      tick(3);
      bus.open_gate = 1'b0;
      e.granted = 1'b0;
      e.code = '0;
      e.cnt  = '0;
      e.rej  = '0;
      push(t + 6);
      tick(1);
    end
    tick(RT);

    // Short PIN enter and non-BCD digits ignored; fifth digit dropped.
    key(4'd1); key(4'd2); key(4'd3);
    pulse_enter_ignored();
    key(4'hA); key(4'hF);
    key(4'd4); key(4'd5);
    tick(2);

    // Clear beats valid and enter in the same cycle.
    bus.key_valid = 1'b1;
    bus.key_digit = 4'd5;
    bus.key_clear = 1'b1;
    bus.key_enter = 1'b1;
    e.code = '0;
    e.cnt  = '0;
    push(cyc + 1);
    tick(1);
    bus.key_valid = 1'b0;
    bus.key_clear = 1'b0;
    bus.key_enter = 1'b0;
    tick(4);
    tick(RT);

    // Four unanswered submissions; rejected saturates at 3.
    for (int i = 0; i < 4; i++) begin
      key(4'd1); key(4'd1); key(4'd1); key(4'd1);
      submit_timeout((i < 3) ? 2'(i + 1) : 2'd3);
    end

    // Both responses in WAIT_RESP: lockout wins.
    key(4'd9); key(4'd9); key(4'd9); key(4'd9);
    submit();
    begin
      int t;
      t = cyc + ACK;
      tick(ACK);
      bus.open_gate = 1'b1;
      bus.blocked_gate = 1'b1;
      e.locked = 1'b1;
      push(t + 1);
      tick(1);
      bus.open_gate = 1'b0;
      bus.blocked_gate = 1'b0;
      tick(3);
    end
    do_reset();
    tick(2);

    // Lockout in the first SEND cycle aborts the strobe; keys are dead until reset.
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    bus.key_enter = 1'b1;
    e.ack = 1'b1;
    push(cyc + 1);
    tick(1);
    bus.key_enter = 1'b0;
    bus.blocked_gate = 1'b1;
    e.ack = 1'b0;
    e.locked = 1'b1;
    push(cyc + 1);
    tick(1);
    bus.blocked_gate = 1'b0;
    bus.key_clear = 1'b1;
    tick(1);
    bus.key_clear = 1'b0;
    bus.key_valid = 1'b1;
    bus.key_digit = 4'd7;
    tick(1);
    bus.key_valid = 1'b0;
    pulse_enter_ignored();
    bus.open_gate = 1'b1;
    tick(2);
    bus.open_gate = 1'b0;
    tick(RT);
    do_reset();
    tick(3);

    while (q.size() != 0) begin
      exp_t x;
      x = q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_change got=none required=%h at cyc=%0d", x.s, x.at);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
